// File: rtl/cpri_pkg.sv
// cpri_pkg: shared constants and types for the CPRI receive deframer.
//   K_CHAR_DEF - default comma byte (K28.5)
//   state_e    - word-alignment FSM states
//   WORD_W     - received word width
//   BEAT_W     - packed output beat width
package cpri_pkg;

  localparam logic [7:0]  K_CHAR_DEF = 8'hBC;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BEAT_W     = 64;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    SYNC   = 2'd2
  } state_e;

endpackage

// File: rtl/cpri_word_packer.sv
// cpri_word_packer: packs 16-bit payload words into 64-bit beats,
// little-endian word order, and flags the first beat of each frame.
// VFIFO full is sampled in the cycle the 4th word arrives; a beat that
// cannot be accepted is dropped and reported on drop_c.
//   clk, rst_n  - clock, synchronous active-low reset
//   word_en     - word is payload to be packed
//   first       - word is word 1 of its frame
//   flush       - discard any partial beat (not in sync)
//   word        - payload word
//   full        - downstream cannot accept a beat
//   data/valid/sof - registered beat outputs
//   drop_c      - combinational: a completed beat is being dropped
module cpri_word_packer
  import cpri_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_en,
  input  logic              first,
  input  logic              flush,
  input  logic [WORD_W-1:0] word,
  input  logic              full,
  output logic [BEAT_W-1:0] data,
  output logic              valid,
  output logic              sof,
  output logic              drop_c
);

  logic [1:0]  idx_q;
  logic [47:0] buf_q;
  logic        sof_pend_q;

  assign drop_c = word_en && !flush && (idx_q == 2'd3) && full;

  // Word accumulation and beat emission
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      buf_q      <= '0;
      sof_pend_q <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      sof        <= 1'b0;
    end else begin
      valid <= 1'b0;
      sof   <= 1'b0;
      if (flush) begin
        idx_q      <= '0;
        sof_pend_q <= 1'b0;
      end else if (word_en) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0: begin
            buf_q[15:0] <= word;
            sof_pend_q  <= first;
          end
          2'd1:    buf_q[31:16] <= word;
          2'd2:    buf_q[47:32] <= word;
          default: begin
            if (!full) begin
              data  <= {word, buf_q};
              valid <= 1'b1;
              sof   <= sof_pend_q;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cpri_rx_deframer.sv
// cpri_rx_deframer: comma-based CPRI frame alignment and payload packing.
// Optional statistics counters are built when CPRI_RX_STATS_EN is defined.
//   CLK_245M76    - recovered data clock
//   RST_N         - synchronous active-low reset
//   Data_in       - received word, comma byte in [7:0]
//   Char_in       - Data_in[7:0] is a K character
//   VFIFO_Full    - downstream FIFO cannot accept a beat
//   Data_Out      - packed 64-bit payload beat, first word in [15:0]
//   Valid_Out     - Data_Out valid
//   Sof_Out       - first beat of a frame (with Valid_Out)
//   Locked_Out    - aligner in SYNC
//   Comma_Err_Cnt - saturating comma error count (stats only)
//   Overflow_Cnt  - saturating dropped-beat count (stats only)
module cpri_rx_deframer
  import cpri_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 65,
  parameter int unsigned SYNC_CNT    = 3,
  parameter int unsigned LOSS_CNT    = 2,
  parameter logic [7:0]  K_CHAR      = K_CHAR_DEF
) (
  input  logic              CLK_245M76,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] Data_in,
  input  logic              Char_in,
  input  logic              VFIFO_Full,
  output logic [BEAT_W-1:0] Data_Out,
  output logic              Valid_Out,
  output logic              Sof_Out,
  output logic              Locked_Out
`ifdef CPRI_RX_STATS_EN
  ,
  output logic [15:0]       Comma_Err_Cnt,
  output logic [15:0]       Overflow_Cnt
`endif
);

  localparam int unsigned WCNT_W = $clog2(FRAME_WORDS);
  localparam int unsigned GOOD_W = $clog2(SYNC_CNT + 1);
  localparam int unsigned ERR_W  = $clog2(LOSS_CNT + 1);

  // Payload must divide evenly into 4-word beats
  if (((FRAME_WORDS - 1) % 4) != 0) begin : g_bad_frame
    $error("cpri_rx_deframer: FRAME_WORDS-1 must be a multiple of 4");
  end

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               comma;
  logic               comma_err_c;
  logic               drop_c;

  assign comma    = Char_in && (Data_in[7:0] == K_CHAR);
  assign wcnt_inc = (wcnt_q == WCNT_W'(FRAME_WORDS - 1)) ? '0 : wcnt_q + WCNT_W'(1);

  // State register
  always_ff @(posedge CLK_245M76) begin
    if (!RST_N) begin
      state_q    <= HUNT;
      wcnt_q     <= '0;
      good_q     <= '0;
      err_q      <= '0;
      Locked_Out <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      good_q     <= good_d;
      err_q      <= err_d;
      Locked_Out <= (state_d == SYNC);
    end
  end

  // Alignment next-state logic
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    good_d      = good_q;
    err_d       = err_q;
    comma_err_c = 1'b0;
    case (state_q)
      HUNT: begin
        wcnt_d = '0;
        if (comma) begin
          state_d = VERIFY;
          wcnt_d  = WCNT_W'(1);
          good_d  = GOOD_W'(1);
        end
      end
      VERIFY: begin
        wcnt_d = wcnt_inc;
        if (wcnt_q == '0) begin
          if (comma) begin
            good_d = good_q + GOOD_W'(1);
            if ((32'(good_q) + 32'd1) >= SYNC_CNT) begin
              state_d = SYNC;
              err_d   = '0;
            end
          end else begin
            state_d = HUNT;
            wcnt_d  = '0;
            good_d  = '0;
          end
        end else if (comma) begin
          // Stray comma: re-anchor the frame on it
          wcnt_d = WCNT_W'(1);
          good_d = GOOD_W'(1);
        end
      end
      SYNC: begin
        wcnt_d = wcnt_inc;
        if (wcnt_q == '0) begin
          if (comma) begin
            err_d = '0;
          end else begin
            comma_err_c = 1'b1;
            if ((32'(err_q) + 32'd1) >= LOSS_CNT) begin
              state_d = HUNT;
              wcnt_d  = '0;
              good_d  = '0;
              err_d   = '0;
            end else begin
              err_d = err_q + ERR_W'(1);
            end
          end
        end else if (comma) begin
          // Misplaced comma stays in the payload but is flagged
          comma_err_c = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        wcnt_d  = '0;
        good_d  = '0;
        err_d   = '0;
      end
    endcase
  end

  cpri_word_packer u_packer (
    .clk     (CLK_245M76),
    .rst_n   (RST_N),
    .word_en ((state_q == SYNC) && (wcnt_q != '0)),
    .first   (wcnt_q == WCNT_W'(1)),
    .flush   (state_q != SYNC),
    .word    (Data_in),
    .full    (VFIFO_Full),
    .data    (Data_Out),
    .valid   (Valid_Out),
    .sof     (Sof_Out),
    .drop_c  (drop_c)
  );

`ifdef CPRI_RX_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge CLK_245M76) begin
    if (!RST_N) begin
      Comma_Err_Cnt <= '0;
      Overflow_Cnt  <= '0;
    end else begin
      if (comma_err_c && (Comma_Err_Cnt != 16'hFFFF)) Comma_Err_Cnt <= Comma_Err_Cnt + 16'd1;
      if (drop_c && (Overflow_Cnt != 16'hFFFF))       Overflow_Cnt  <= Overflow_Cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{comma_err_c, drop_c};
`endif

endmodule
